// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage. Registers execute results, runs loads/stores
// over an SRAM-like data bus and hands aligned, extended results to writeback.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_allowin,
   input  logic [31:0] ea,
   input  logic [31:0] eb,
   input  logic [4:0]  ern,
   input  logic [6:0]  except,
   input  logic [3:0]  mem_op,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        out_valid,
   input  logic        out_allowin,
   output logic [31:0] result,
   output logic [4:0]  wrn,
   output logic [6:0]  o_except,
   output logic [31:0] bad_vaddr
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

   function automatic logic op_is_load(input logic [3:0] op);
      op_is_load = (op >= OP_LB) && (op <= OP_LW);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      op_is_store = (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
      op_misaligned = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: op_misaligned = addr_lo[0];
         OP_LW, OP_SW:         op_misaligned = |addr_lo;
         default:              op_misaligned = 1'b0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        valid_q, valid_d;
   logic        bus_q, bus_d;
   logic [31:0] ea_q, ea_d;
   logic [31:0] eb_q, eb_d;
   logic [4:0]  ern_q, ern_d;
   logic [4:0]  exc_q, exc_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] rdata_q, rdata_d;

   logic        in_go_bus;
   logic        capture;
   logic        q_load;
   logic        q_store;
   logic        q_mis;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // An instruction only touches the bus when it is a memory op with no exception at all.
   assign in_go_bus = (op_is_load(mem_op) || op_is_store(mem_op)) && (except == 7'd0)
                      && !op_misaligned(mem_op, ea[1:0]);
   assign capture   = in_valid && in_allowin && !flush;

   assign q_load  = op_is_load(op_q);
   assign q_store = op_is_store(op_q);
   assign q_mis   = op_misaligned(op_q, ea_q[1:0]);

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      bus_d      = bus_q;
      ea_d       = ea_q;
      eb_d       = eb_q;
      ern_d      = ern_q;
      exc_d      = exc_q;
      op_d       = op_q;
      rdata_d    = rdata_q;
      in_allowin = 1'b0;
      data_req   = 1'b0;
      out_valid  = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_allowin = !valid_q;
            if (flush) begin
               valid_d = 1'b0;
            end else if (valid_q) begin
               state_d = bus_q ? S_REQ : S_DONE;
            end
         end
         S_REQ: begin
            data_req = 1'b1;
            if (flush) begin
               valid_d = 1'b0;
               state_d = data_addr_ok ? S_CANCEL : S_IDLE;
            end else if (data_addr_ok) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush) begin
               valid_d = 1'b0;
               state_d = data_data_ok ? S_IDLE : S_CANCEL;
            end else if (data_data_ok) begin
               rdata_d = data_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            // Retiring frees the stage in the same cycle, so a follower can enter back-to-back.
            in_allowin = out_allowin;
            if (flush || out_allowin) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_CANCEL: begin
            if (data_data_ok) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (capture) begin
         valid_d = 1'b1;
         bus_d   = in_go_bus;
         ea_d    = ea;
         eb_d    = eb;
         ern_d   = ern;
         exc_d   = except[6:2];
         op_d    = mem_op;
         state_d = in_go_bus ? S_REQ : S_DONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
         bus_q   <= 1'b0;
         ea_q    <= 32'd0;
         eb_q    <= 32'd0;
         ern_q   <= 5'd0;
         exc_q   <= 5'd0;
         op_q    <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         bus_q   <= bus_d;
         ea_q    <= ea_d;
         eb_q    <= eb_d;
         ern_q   <= ern_d;
         exc_q   <= exc_d;
         op_q    <= op_d;
         rdata_q <= rdata_d;
      end
   end

   assign data_addr = ea_q;
   assign data_wr   = q_store;
   assign wrn       = ern_q;
   assign bad_vaddr = ea_q;
   assign o_except  = {exc_q, q_load && q_mis, q_store && q_mis};

   always_comb begin
      data_size  = 2'd0;
      data_wdata = eb_q;
      case (op_q)
         OP_LH, OP_LHU: data_size = 2'd1;
         OP_LW, OP_SW:  data_size = 2'd2;
         OP_SB:         data_wdata = {4{eb_q[7:0]}};
         OP_SH: begin
            data_size  = 2'd1;
            data_wdata = {2{eb_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = rdata_q[7:0];
      case (ea_q[1:0])
         2'd1:    ld_byte = rdata_q[15:8];
         2'd2:    ld_byte = rdata_q[23:16];
         2'd3:    ld_byte = rdata_q[31:24];
         default: ld_byte = rdata_q[7:0];
      endcase
      ld_half = ea_q[1] ? rdata_q[31:16] : rdata_q[15:0];

      result = ea_q;
      if (bus_q) begin
         case (op_q)
            OP_LB:   result = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  result = {24'd0, ld_byte};
            OP_LH:   result = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  result = {16'd0, ld_half};
            OP_LW:   result = rdata_q;
            default: result = ea_q;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic against a transaction-level
// model of the memory stage, with a randomly delaying memory slave and writeback sink.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_allowin;
   logic [31:0] ea;
   logic [31:0] eb;
   logic [4:0]  ern;
   logic [6:0]  except;
   logic [3:0]  mem_op;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        out_valid;
   logic        out_allowin;
   logic [31:0] result;
   logic [4:0]  wrn;
   logic [6:0]  o_except;
   logic [31:0] bad_vaddr;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [4:0]  rn;
      logic [6:0]  exc;
      logic [31:0] rdata;
   } instr_t;

   instr_t q[$];
   bit     owed;

   mem_stage dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_allowin(in_allowin),
      .ea(ea), .eb(eb), .ern(ern), .except(except), .mem_op(mem_op),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .out_valid(out_valid), .out_allowin(out_allowin),
      .result(result), .wrn(wrn), .o_except(o_except), .bad_vaddr(bad_vaddr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_load(instr_t t);
      return t.op >= 1 && t.op <= 5;
   endfunction

   function automatic bit m_store(instr_t t);
      return t.op >= 6 && t.op <= 8;
   endfunction

   function automatic bit m_mis(instr_t t);
      if (t.op == 3 || t.op == 4 || t.op == 7) return (t.ea % 2) != 0;
      if (t.op == 5 || t.op == 8) return (t.ea % 4) != 0;
      return 0;
   endfunction

   function automatic bit m_bus(instr_t t);
      return (m_load(t) || m_store(t)) && t.exc == 0 && !m_mis(t);
   endfunction

   function automatic logic [31:0] m_oexc(instr_t t);
      logic [31:0] v;
      v = 32'(t.exc) & 32'h7C;
      if (m_load(t) && m_mis(t)) v = v + 2;
      if (m_store(t) && m_mis(t)) v = v + 1;
      return v;
   endfunction

   function automatic logic [31:0] m_result(instr_t t);
      logic [31:0] b, h;
      b = (t.rdata >> (8 * (t.ea % 4))) & 32'hFF;
      h = (t.rdata >> (16 * ((t.ea / 2) % 2))) & 32'hFFFF;
      if (!m_bus(t) || !m_load(t)) return t.ea;
      case (t.op)
         1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
         2: return b;
         3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
         4: return h;
         default: return t.rdata;
      endcase
   endfunction

   function automatic logic [31:0] m_size(instr_t t);
      if (t.op == 3 || t.op == 4 || t.op == 7) return 1;
      if (t.op == 5 || t.op == 8) return 2;
      return 0;
   endfunction

   function automatic logic [31:0] m_wdata(instr_t t);
      if (t.op == 6) return (t.eb & 32'hFF) * 32'h01010101;
      if (t.op == 7) return (t.eb & 32'hFFFF) * 32'h00010001;
      return t.eb;
   endfunction

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rn, input logic [6:0] x);
      check_val("issue_allowin", 32'(in_allowin), 32'd1);
      in_valid = 1'b1; mem_op = op; ea = a; eb = b; ern = rn; except = x;
      step();
      in_valid = 1'b0;
   endtask

   task automatic retire();
      out_allowin = 1'b1;
      step();
      out_allowin = 1'b0;
   endtask

   task automatic check_reset_state(input string pfx);
      check_val({pfx, "_in_allowin"}, 32'(in_allowin), 32'd1);
      check_val({pfx, "_data_req"}, 32'(data_req), 32'd0);
      check_val({pfx, "_data_wr"}, 32'(data_wr), 32'd0);
      check_val({pfx, "_data_size"}, 32'(data_size), 32'd0);
      check_val({pfx, "_data_addr"}, data_addr, 32'd0);
      check_val({pfx, "_data_wdata"}, data_wdata, 32'd0);
      check_val({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
      check_val({pfx, "_result"}, result, 32'd0);
      check_val({pfx, "_wrn"}, 32'(wrn), 32'd0);
      check_val({pfx, "_o_except"}, 32'(o_except), 32'd0);
      check_val({pfx, "_bad_vaddr"}, bad_vaddr, 32'd0);
   endtask

   function automatic instr_t rand_instr();
      instr_t t;
      t.op  = 4'($urandom_range(0, 15));
      t.ea  = $urandom;
      if ($urandom_range(0, 1) == 1) t.ea[1:0] = 2'b00;
      t.eb  = $urandom;
      t.rn  = 5'($urandom_range(0, 31));
      t.exc = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 31) << 2) : 7'd0;
      t.rdata = $urandom;
      return t;
   endfunction

   // One cycle of randomized traffic; drain mode offers no input and never stalls.
   task automatic rand_cycle(input bit drain);
      instr_t t, n;
      bit cap, ret, aok, dok, fl;
      if (out_valid) begin
         check_val("ov_has_instr", 32'(q.size()), 32'd1);
         if (q.size() > 0) begin
            t = q[0];
            check_val("result", result, m_result(t));
            check_val("wrn", 32'(wrn), 32'(t.rn));
            check_val("o_except", 32'(o_except), m_oexc(t));
            if ((m_oexc(t) & 32'h3) != 0) check_val("bad_vaddr", bad_vaddr, t.ea);
            check_val("req_in_done", 32'(data_req), 32'd0);
         end
      end
      if (data_req) begin
         check_val("req_has_instr", 32'(q.size()), 32'd1);
         if (q.size() > 0) begin
            t = q[0];
            check_val("req_expected", 32'(m_bus(t)), 32'd1);
            check_val("req_addr", data_addr, t.ea);
            check_val("req_wr", 32'(data_wr), 32'(m_store(t)));
            check_val("req_size", 32'(data_size), m_size(t));
            if (m_store(t)) check_val("req_wdata", data_wdata, m_wdata(t));
         end
      end
      if (owed) check_val("req_while_owed", 32'(data_req), 32'd0);

      fl = !drain && ($urandom_range(0, 99) < 3);
      flush        = fl;
      out_allowin  = drain || ($urandom_range(0, 9) < 7);
      data_addr_ok = data_req && (drain || $urandom_range(0, 1) == 1);
      data_data_ok = owed && (drain || $urandom_range(0, 1) == 1);
      data_rdata   = (owed && q.size() > 0) ? q[0].rdata : $urandom;
      n = rand_instr();
      in_valid = !drain && ($urandom_range(0, 9) < 6);
      mem_op = n.op; ea = n.ea; eb = n.eb; ern = n.rn; except = n.exc;
      #1;
      cap = in_valid && in_allowin && !fl;
      ret = out_valid && out_allowin;
      aok = data_req && data_addr_ok;
      dok = data_data_ok;
      step();
      if (fl || ret) q.delete();
      if (cap) q.push_back(n);
      if (aok) owed = 1;
      if (dok) owed = 0;
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0;
      ea = '0; eb = '0; ern = '0; except = '0; mem_op = '0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; out_allowin = 1'b0;
      owed = 0;
      step(); step();
      check_reset_state("rst");
      resetn = 1'b1;
      step();

      // NONE op: one-cycle latency, result is ea
      issue(4'd0, 32'h1234, 32'd0, 5'd5, 7'd0);
      $display("NONE ea=0x1234 -> out_valid=%0d result=0x%08h wrn=%0d", out_valid, result, wrn);
      check_val("none_out_valid", 32'(out_valid), 32'd1);
      check_val("none_result", result, 32'h1234);
      check_val("none_wrn", 32'(wrn), 32'd5);
      check_val("none_req", 32'(data_req), 32'd0);
      retire();
      check_val("none_retired", 32'(out_valid), 32'd0);

      // LB sign-extend with two wait cycles
      issue(4'd1, 32'h80000003, 32'd0, 5'd7, 7'd0);
      check_val("lb_req", 32'(data_req), 32'd1);
      check_val("lb_size", 32'(data_size), 32'd0);
      check_val("lb_wr", 32'(data_wr), 32'd0);
      check_val("lb_addr", data_addr, 32'h80000003);
      check_val("lb_allowin_req", 32'(in_allowin), 32'd0);
      data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_val("lb_allowin_wait", 32'(in_allowin), 32'd0);
         check_val("lb_req_wait", 32'(data_req), 32'd0);
         step();
      end
      data_data_ok = 1'b1; data_rdata = 32'h80FF1234;
      step();
      data_data_ok = 1'b0;
      $display("LB ea=0x80000003 rdata=0x80FF1234 -> result=0x%08h", result);
      check_val("lb_out_valid", 32'(out_valid), 32'd1);
      check_val("lb_result", result, 32'hFFFFFF80);
      check_val("lb_wrn", 32'(wrn), 32'd7);
      check_val("lb_allowin_done", 32'(in_allowin), 32'd0);
      retire();

      // SH replication, request held while addr_ok low
      issue(4'd7, 32'h102, 32'hAAAABEEF, 5'd0, 7'd0);
      for (int i = 0; i < 3; i++) begin
         check_val("sh_req", 32'(data_req), 32'd1);
         check_val("sh_wr", 32'(data_wr), 32'd1);
         check_val("sh_size", 32'(data_size), 32'd1);
         check_val("sh_wdata", data_wdata, 32'hBEEFBEEF);
         check_val("sh_addr", data_addr, 32'h102);
         step();
      end
      data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
      data_data_ok = 1'b1; step(); data_data_ok = 1'b0;
      $display("SH ea=0x102 eb=0xAAAABEEF -> out_valid=%0d result=0x%08h", out_valid, result);
      check_val("sh_out_valid", 32'(out_valid), 32'd1);
      check_val("sh_result", result, 32'h102);
      retire();

      // Misaligned LW and SW carrying an incoming exception
      issue(4'd5, 32'h101, 32'd0, 5'd3, 7'd0);
      $display("LW ea=0x101 -> o_except=0x%02h bad_vaddr=0x%08h", o_except, bad_vaddr);
      check_val("mlw_req", 32'(data_req), 32'd0);
      check_val("mlw_out_valid", 32'(out_valid), 32'd1);
      check_val("mlw_o_except", 32'(o_except), 32'h02);
      check_val("mlw_bad_vaddr", bad_vaddr, 32'h101);
      retire();
      issue(4'd8, 32'h200, 32'h1, 5'd4, 7'b0001000);
      $display("SW exc=0x08 -> o_except=0x%02h", o_except);
      check_val("xsw_req", 32'(data_req), 32'd0);
      check_val("xsw_out_valid", 32'(out_valid), 32'd1);
      check_val("xsw_o_except", 32'(o_except), 32'h08);
      retire();

      // Flush while waiting for data
      issue(4'd5, 32'h40, 32'd0, 5'd9, 7'd0);
      data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
      flush = 1'b1; step(); flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_val("fl_out_valid", 32'(out_valid), 32'd0);
         check_val("fl_allowin", 32'(in_allowin), 32'd0);
         check_val("fl_req", 32'(data_req), 32'd0);
         step();
      end
      data_data_ok = 1'b1; data_rdata = 32'h12345678;
      step();
      data_data_ok = 1'b0;
      $display("flush in WAIT -> after data_ok in_allowin=%0d out_valid=%0d", in_allowin, out_valid);
      check_val("fl_allowin_back", 32'(in_allowin), 32'd1);
      check_val("fl_out_valid_after", 32'(out_valid), 32'd0);

      // Writeback stall, then back-to-back capture as out_allowin rises
      issue(4'd0, 32'hCAFE, 32'd0, 5'd11, 7'd0);
      for (int i = 0; i < 4; i++) begin
         check_val("stall_out_valid", 32'(out_valid), 32'd1);
         check_val("stall_result", result, 32'hCAFE);
         check_val("stall_wrn", 32'(wrn), 32'd11);
         step();
      end
      out_allowin = 1'b1; in_valid = 1'b1; mem_op = 4'd0; ea = 32'h55; ern = 5'd12; except = 7'd0;
      #1;
      check_val("stall_allowin_rise", 32'(in_allowin), 32'd1);
      step();
      in_valid = 1'b0; out_allowin = 1'b0;
      $display("stall release -> next result=0x%08h wrn=%0d", result, wrn);
      check_val("b2b_out_valid", 32'(out_valid), 32'd1);
      check_val("b2b_result", result, 32'h55);
      check_val("b2b_wrn", 32'(wrn), 32'd12);

      // Flush together with out_allowin and in_valid in DONE: nothing captured
      flush = 1'b1; out_allowin = 1'b1; in_valid = 1'b1; mem_op = 4'd5; ea = 32'h300;
      step();
      flush = 1'b0; out_allowin = 1'b0; in_valid = 1'b0;
      check_val("flcap_out_valid", 32'(out_valid), 32'd0);
      check_val("flcap_req", 32'(data_req), 32'd0);
      check_val("flcap_allowin", 32'(in_allowin), 32'd1);

      // Asynchronous reset in the middle of an access
      issue(4'd1, 32'h80, 32'd0, 5'd2, 7'd0);
      data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
      resetn = 1'b0;
      #1;
      check_reset_state("rst_mid");
      #2;
      resetn = 1'b1;
      step();

      // Randomized traffic against the model, then drain
      q.delete();
      owed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) rand_cycle(1'b0);
      for (int cyc = 0; cyc < 20 && (q.size() > 0 || owed); cyc++) rand_cycle(1'b1);
      flush = 1'b0; in_valid = 1'b0;
      $display("random phase drained: pending=%0d owed=%0d", q.size(), owed);
      check_val("drain_empty", 32'(q.size()), 32'd0);
      check_val("drain_owed", 32'(owed), 32'd0);
      check_val("drain_allowin", 32'(in_allowin), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
